// File: rtl/writeback_unit_pkg.sv
// Shared core constants for the writeback stage: default datapath sizes,
// the load-starvation threshold and the result-source selector.
package writeback_unit_pkg;

   localparam int WB_DATA_WIDTH     = 32;
   localparam int WB_REGISTERS      = 32;
   localparam int WB_LOG2_REGISTERS = 5;

   localparam int STARVE_W = 2;
   localparam logic [STARVE_W-1:0] WB_STARVE_LIMIT = 2'd3;

   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_ALU  = 2'd1,
      WB_SRC_MEM  = 2'd2
   } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write vector for issue-stage hazard detection. A set and a clear
// of the same index in one cycle leaves the bit set; index 0 never pends.
module wb_scoreboard
   import writeback_unit_pkg::*;
#(
   parameter int REGISTERS      = WB_REGISTERS,
   parameter int LOG2_REGISTERS = WB_LOG2_REGISTERS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      set_valid_i,
   input  logic [LOG2_REGISTERS-1:0] set_idx_i,
   input  logic                      clr_valid_i,
   input  logic [LOG2_REGISTERS-1:0] clr_idx_i,
   input  logic [LOG2_REGISTERS-1:0] query_a_i,
   input  logic [LOG2_REGISTERS-1:0] query_b_i,
   output logic                      busy_a_o,
   output logic                      busy_b_o
);

   logic [REGISTERS-1:0] pending_q;
   logic [REGISTERS-1:0] pending_d;

   // Next pending vector: the set term is OR-ed in after the clear, so the newer issue wins.
   always_comb begin
      pending_d = '0;
      for (int i = 0; i < REGISTERS; i++) begin
         pending_d[i] = (set_valid_i && (set_idx_i == LOG2_REGISTERS'(i))) ||
                        (pending_q[i] && !(clr_valid_i && (clr_idx_i == LOG2_REGISTERS'(i))));
      end
      pending_d[0] = 1'b0;
   end

   // Pending vector register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign busy_a_o = pending_q[query_a_i];
   assign busy_b_o = pending_q[query_b_i];

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates ALU and load results into one registered
// register-file write port, tracks pending writes and bypasses the in-flight write.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int DATA_WIDTH     = WB_DATA_WIDTH,
   parameter int REGISTERS      = WB_REGISTERS,
   parameter int LOG2_REGISTERS = WB_LOG2_REGISTERS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [LOG2_REGISTERS-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]     alu_data,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [LOG2_REGISTERS-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]     mem_data,
   input  logic                      issue_valid,
   input  logic [LOG2_REGISTERS-1:0] issue_rd,
   input  logic [LOG2_REGISTERS-1:0] addr_rs1,
   input  logic [LOG2_REGISTERS-1:0] addr_rs2,
   input  logic [DATA_WIDTH-1:0]     rf_rs1,
   input  logic [DATA_WIDTH-1:0]     rf_rs2,
   output logic [DATA_WIDTH-1:0]     op_rs1,
   output logic [DATA_WIDTH-1:0]     op_rs2,
   output logic                      rs1_busy,
   output logic                      rs2_busy,
   output logic [LOG2_REGISTERS-1:0] addr_rd,
   output logic [DATA_WIDTH-1:0]     data_rd
);

   logic [STARVE_W-1:0]       starve_q;
   logic [STARVE_W-1:0]       starve_d;
   logic [LOG2_REGISTERS-1:0] addr_rd_q;
   logic [LOG2_REGISTERS-1:0] addr_rd_d;
   logic [DATA_WIDTH-1:0]     data_rd_q;
   logic [DATA_WIDTH-1:0]     data_rd_d;
   logic                      starved_s;
   logic                      alu_accept_s;
   logic                      mem_accept_s;
   wb_src_e                   wb_src_s;

   // Arbitration: mem_ready is the inverse of alu_ready, so the two are never high together.
   always_comb begin
      starved_s    = (starve_q == WB_STARVE_LIMIT);
      mem_ready    = !alu_valid || starved_s;
      alu_ready    = !mem_ready;
      alu_accept_s = alu_valid && alu_ready;
      mem_accept_s = mem_valid && mem_ready;
   end

   // Source select, output-register next state and starvation counter next state.
   always_comb begin
      wb_src_s  = WB_SRC_NONE;
      addr_rd_d = '0;
      data_rd_d = '0;
      starve_d  = starve_q;
      if (alu_accept_s) begin
         wb_src_s = WB_SRC_ALU;
      end else if (mem_accept_s) begin
         wb_src_s = WB_SRC_MEM;
      end else begin
         wb_src_s = WB_SRC_NONE;
      end
      case (wb_src_s)
         WB_SRC_ALU: begin
            addr_rd_d = alu_rd;
            data_rd_d = alu_data;
         end
         WB_SRC_MEM: begin
            addr_rd_d = mem_rd;
            data_rd_d = mem_data;
         end
         default: begin
            addr_rd_d = '0;
            data_rd_d = '0;
         end
      endcase
      if (!mem_valid || mem_accept_s) begin
         starve_d = '0;
      end else if (!starved_s) begin
         starve_d = starve_q + 2'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // Output write-port register and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_rd_q <= '0;
         data_rd_q <= '0;
         starve_q  <= '0;
      end else begin
         addr_rd_q <= addr_rd_d;
         data_rd_q <= data_rd_d;
         starve_q  <= starve_d;
      end
   end

   wb_scoreboard #(
      .REGISTERS      (REGISTERS),
      .LOG2_REGISTERS (LOG2_REGISTERS)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .set_valid_i (issue_valid),
      .set_idx_i   (issue_rd),
      .clr_valid_i (alu_accept_s || mem_accept_s),
      .clr_idx_i   (addr_rd_d),
      .query_a_i   (addr_rs1),
      .query_b_i   (addr_rs2),
      .busy_a_o    (rs1_busy),
      .busy_b_o    (rs2_busy)
   );

   // Bypass covers the cycle the write sits in the port before the register file commits it.
   always_comb begin
      op_rs1 = ((addr_rd_q != '0) && (addr_rd_q == addr_rs1)) ? data_rd_q : rf_rs1;
      op_rs2 = ((addr_rd_q != '0) && (addr_rd_q == addr_rs2)) ? data_rd_q : rf_rs2;
   end

   assign addr_rd = addr_rd_q;
   assign data_rd = data_rd_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_writeback_unit;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  addr_rs1;
   logic [4:0]  addr_rs2;
   logic [31:0] rf_rs1;
   logic [31:0] rf_rs2;
   logic [31:0] op_rs1;
   logic [31:0] op_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic [4:0]  addr_rd;
   logic [31:0] data_rd;

   int checks = 0;
   int errors = 0;
   int obs_alu_acc = 0;
   int obs_mem_acc = 0;

   // Behavioural model state
   bit          m_pend [32];
   logic [4:0]  m_addr = 5'd0;
   logic [31:0] m_data = 32'd0;
   int          m_wait = 0;

   writeback_unit dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .addr_rs1    (addr_rs1),
      .addr_rs2    (addr_rs2),
      .rf_rs1      (rf_rs1),
      .rf_rs2      (rf_rs2),
      .op_rs1      (op_rs1),
      .op_rs2      (op_rs2),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .addr_rd     (addr_rd),
      .data_rd     (data_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%08h expected=0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      alu_valid   = 1'b0;
      alu_rd      = 5'd0;
      alu_data    = 32'd0;
      mem_valid   = 1'b0;
      mem_rd      = 5'd0;
      mem_data    = 32'd0;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
   endtask

   // Called just after a falling edge with inputs applied; checks the cycle,
   // advances the model across the rising edge and returns at the next falling edge.
   task automatic run_cycle();
      bit          exp_mem_rdy;
      bit          exp_alu_rdy;
      bit          alu_take;
      bit          mem_take;
      logic [4:0]  n_addr;
      logic [31:0] n_data;
      #2;
      // Load side gets the port when ALU is idle or after waiting three cycles.
      exp_mem_rdy = !alu_valid || (m_wait >= 3);
      exp_alu_rdy = !exp_mem_rdy;
      check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, exp_alu_rdy});
      check_eq("mem_ready", {31'd0, mem_ready}, {31'd0, exp_mem_rdy});
      check_eq("ready_exclusive", {31'd0, alu_ready & mem_ready}, 32'd0);
      check_eq("addr_rd", {27'd0, addr_rd}, {27'd0, m_addr});
      check_eq("data_rd", data_rd, m_data);
      check_eq("rs1_busy", {31'd0, rs1_busy}, {31'd0, (addr_rs1 != 5'd0) && m_pend[addr_rs1]});
      check_eq("rs2_busy", {31'd0, rs2_busy}, {31'd0, (addr_rs2 != 5'd0) && m_pend[addr_rs2]});
      check_eq("op_rs1", op_rs1, (m_addr != 5'd0 && m_addr == addr_rs1) ? m_data : rf_rs1);
      check_eq("op_rs2", op_rs2, (m_addr != 5'd0 && m_addr == addr_rs2) ? m_data : rf_rs2);
      if (alu_valid && alu_ready) obs_alu_acc++;
      if (mem_valid && mem_ready) obs_mem_acc++;

      alu_take = alu_valid && exp_alu_rdy;
      mem_take = mem_valid && exp_mem_rdy;
      n_addr   = alu_take ? alu_rd   : (mem_take ? mem_rd   : 5'd0);
      n_data   = alu_take ? alu_data : (mem_take ? mem_data : 32'd0);
      @(posedge clk);
      if (rst) begin
         m_addr = 5'd0;
         m_data = 32'd0;
         m_wait = 0;
         foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
         m_addr = n_addr;
         m_data = n_data;
         m_wait = (mem_valid && !mem_take) ? ((m_wait < 3) ? m_wait + 1 : 3) : 0;
         if ((alu_take || mem_take) && n_addr != 5'd0) m_pend[n_addr] = 1'b0;
         if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      idle_inputs();
      addr_rs1 = 5'd0;
      addr_rs2 = 5'd0;
      rf_rs1   = 32'd0;
      rf_rs2   = 32'd0;
      rst      = 1'b1;
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'hA5A5_0005;
      @(posedge clk);
      @(negedge clk);

      // Reset held with a valid ALU result pending
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check_eq("reset_addr_rd", {27'd0, addr_rd}, 32'd0);
         check_eq("reset_data_rd", data_rd, 32'd0);
      end
      rst = 1'b0;
      run_cycle();
      check_eq("first_accept_addr", {27'd0, addr_rd}, 32'd5);
      check_eq("first_accept_data", data_rd, 32'hA5A5_0005);

      // Single ALU write
      alu_rd   = 5'd3;
      alu_data = 32'hDEAD_BEEF;
      run_cycle();
      check_eq("alu_write_addr", {27'd0, addr_rd}, 32'd3);
      check_eq("alu_write_data", data_rd, 32'hDEAD_BEEF);
      idle_inputs();
      run_cycle();
      check_eq("idle_addr_rd", {27'd0, addr_rd}, 32'd0);

      // Issue rd=7, load result for rd=7 three cycles later
      addr_rs1    = 5'd7;
      rf_rs1      = 32'd0;
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      run_cycle();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         check_eq("sb_busy_wait", {31'd0, rs1_busy}, 32'd1);
         run_cycle();
      end
      check_eq("sb_busy_wait", {31'd0, rs1_busy}, 32'd1);
      mem_valid = 1'b1;
      mem_rd    = 5'd7;
      mem_data  = 32'h0000_0055;
      run_cycle();
      idle_inputs();
      check_eq("sb_busy_cleared", {31'd0, rs1_busy}, 32'd0);
      check_eq("sb_bypass_op", op_rs1, 32'h0000_0055);
      run_cycle();

      // Both sources valid continuously: three ALU accepts then one load accept
      obs_alu_acc = 0;
      obs_mem_acc = 0;
      alu_valid = 1'b1;
      alu_rd    = 5'd1;
      alu_data  = 32'h1111_1111;
      mem_valid = 1'b1;
      mem_rd    = 5'd2;
      mem_data  = 32'h2222_2222;
      for (int i = 0; i < 12; i++) begin
         run_cycle();
         alu_data = alu_data + 32'd1;
         mem_data = mem_data + 32'd1;
      end
      check_eq("starve_alu_count", obs_alu_acc, 32'd9);
      check_eq("starve_mem_count", obs_mem_acc, 32'd3);
      idle_inputs();
      run_cycle();

      // Issue and writeback of rd=9 in the same cycle
      addr_rs1    = 5'd9;
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      alu_valid   = 1'b1;
      alu_rd      = 5'd9;
      alu_data    = 32'h0000_0909;
      run_cycle();
      idle_inputs();
      check_eq("set_wins_busy", {31'd0, rs1_busy}, 32'd1);
      run_cycle();

      // x0: issue and writeback to register 0
      addr_rs1    = 5'd0;
      addr_rs2    = 5'd0;
      rf_rs1      = 32'h1234_5678;
      rf_rs2      = 32'h8765_4321;
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      alu_valid   = 1'b1;
      alu_rd      = 5'd0;
      alu_data    = 32'hFFFF_FFFF;
      run_cycle();
      idle_inputs();
      check_eq("x0_rs1_busy", {31'd0, rs1_busy}, 32'd0);
      check_eq("x0_rs2_busy", {31'd0, rs2_busy}, 32'd0);
      check_eq("x0_op_rs1", op_rs1, 32'h1234_5678);
      run_cycle();

      // Randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 99) == 0);
         alu_valid   = $urandom_range(0, 1);
         alu_rd      = 5'($urandom_range(0, 7));
         alu_data    = $urandom;
         mem_valid   = ($urandom_range(0, 3) != 0);
         mem_rd      = 5'($urandom_range(0, 7));
         mem_data    = $urandom;
         issue_valid = $urandom_range(0, 1);
         issue_rd    = 5'($urandom_range(0, 7));
         addr_rs1    = 5'($urandom_range(0, 7));
         addr_rs2    = 5'($urandom_range(0, 7));
         rf_rs1      = $urandom;
         rf_rs2      = $urandom;
         run_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
